// File: rtl/tc_div_pkg.sv
// Shared widths, saturation limits and FSM encoding for the sequential divider.
package tc_div_pkg;

  localparam int DIVIDEND_W_DEF = 28;
  localparam int DIVISOR_W_DEF  = 17;
  localparam int QUOT_W_DEF     = 11;

  // Saturation limits of a signed quotient of the given width.
  function automatic longint sat_pos(input int qw);
    return (64'sd1 <<< (qw - 1)) - 1;
  endfunction

  function automatic longint sat_neg(input int qw);
    return -(64'sd1 <<< (qw - 1));
  endfunction

  localparam longint Q_MAX_DEF = sat_pos(QUOT_W_DEF);  // 1023
  localparam longint Q_MIN_DEF = sat_neg(QUOT_W_DEF);  // -1024

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tc_div_step.sv
// One combinational restoring-division step.
module tc_div_step #(
  parameter int DIVISOR_W = 17
) (
  input  logic [DIVISOR_W:0]   rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W+1:0] diff;

  // Shift in the next dividend bit, trial-subtract, keep the difference if it did not go negative.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[DIVISOR_W+1];
    rem_out = q_bit ? diff[DIVISOR_W:0] : shifted[DIVISOR_W:0];
  end

endmodule

// File: rtl/tc_l1l2f_div_28s_17ns_11s.sv
// Sequential signed/unsigned restoring divider, one quotient bit per cycle,
// with saturated signed quotient and dividend-signed remainder.
module tc_l1l2f_div_28s_17ns_11s
  import tc_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF,
  parameter int QUOT_W     = QUOT_W_DEF
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]        divisor,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [QUOT_W-1:0]    quotient,
  output logic signed [DIVISOR_W:0]   remainder,
  output logic                        ovf,
  output logic                        dz
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  // Magnitude limits: positive results saturate above POS_LIM, negative above POS_LIM+1.
  localparam logic [DIVIDEND_W-1:0] POS_LIM = DIVIDEND_W'(sat_pos(QUOT_W));
  localparam logic [DIVIDEND_W-1:0] NEG_LIM = DIVIDEND_W'(-sat_neg(QUOT_W));
  localparam logic signed [QUOT_W-1:0] Q_MAX = QUOT_W'(sat_pos(QUOT_W));
  localparam logic signed [QUOT_W-1:0] Q_MIN = QUOT_W'(sat_neg(QUOT_W));

  state_t state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] mag;      // dividend magnitude shifting out, quotient shifting in
  logic [DIVISOR_W:0]    prem;     // partial remainder
  logic [DIVISOR_W-1:0]  dvs;
  logic                  neg;
  logic                  dz_r;
  logic                  last;

  logic [DIVISOR_W:0]    step_rem;
  logic                  step_q;
  logic [DIVIDEND_W-1:0] qmag;
  logic signed [QUOT_W-1:0]  fin_q;
  logic signed [DIVISOR_W:0] fin_r;
  logic                      fin_ovf;

  tc_div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .rem_in  (prem),
    .bit_in  (mag[DIVIDEND_W-1]),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign last      = (cnt == CNT_W'(DIVIDEND_W - 1));
  assign qmag      = {mag[DIVIDEND_W-2:0], step_q};
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Next state: accept in IDLE, run DIVIDEND_W steps, hold result until consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result formatting from the final step: sign correction, saturation, divide-by-zero override.
  always_comb begin
    fin_ovf = 1'b0;
    fin_r   = neg ? -step_rem : step_rem;
    fin_q   = neg ? -qmag[QUOT_W-1:0] : qmag[QUOT_W-1:0];
    if (dz_r) begin
      fin_q = neg ? Q_MIN : Q_MAX;
      fin_r = '0;
    end else if (!neg && qmag > POS_LIM) begin
      fin_q   = Q_MAX;
      fin_ovf = 1'b1;
    end else if (neg && qmag > NEG_LIM) begin
      fin_q   = Q_MIN;
      fin_ovf = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt       <= '0;
      mag       <= '0;
      prem      <= '0;
      dvs       <= '0;
      neg       <= 1'b0;
      dz_r      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mag  <= dividend[DIVIDEND_W-1] ? (~dividend + 1'b1) : dividend;
          neg  <= dividend[DIVIDEND_W-1];
          dvs  <= divisor;
          dz_r <= (divisor == '0);
          prem <= '0;
          cnt  <= '0;
        end
        CALC: begin
          mag  <= qmag;
          prem <= step_rem;
          cnt  <= cnt + 1'b1;
          if (last) begin
            quotient  <= fin_q;
            remainder <= fin_r;
            ovf       <= fin_ovf;
            dz        <= dz_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
